// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter with latched transaction registers.
// Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_busy,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_prio;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_m0_done;
  logic        r_m1_done;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_complete;
  logic        w_timeout;
  logic [31:0] w_cap_data;

`ifdef BUS_TIMEOUT_EN
  logic [3:0] r_cnt;
  logic       r_err;

  assign w_timeout = (r_state != IDLE) && !bus_ready && (r_cnt == 4'd15);
  assign bus_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
      r_err <= 1'b0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_cnt <= 4'd0;
      end else if ((r_state != IDLE) && !bus_ready) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // Timeout completion returns a poison value regardless of direction.
  assign w_cap_data = w_timeout ? 32'hDEAD_BEEF : (r_we ? 32'h0 : bus_rdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    w_complete   = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = 32'hFFFF_FFFF;
    bus_wdata    = 32'h0;
    case (r_state)
      IDLE: begin
        if (m0_req && (!m1_req || !r_prio)) begin
          w_grant0     = 1'b1;
          w_state_next = GNT0;
        end else if (m1_req) begin
          w_grant1     = 1'b1;
          w_state_next = GNT1;
        end
      end
      GNT0, GNT1: begin
        bus_we    = r_we;
        bus_addr  = r_addr;
        bus_wdata = r_wdata;
        if (bus_ready || w_timeout) begin
          w_complete   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_m0_done  <= 1'b0;
      r_m1_done  <= 1'b0;
      r_m0_rdata <= 32'h0;
      r_m1_rdata <= 32'h0;
    end else begin
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      if (w_grant0) begin
        r_we    <= m0_we;
        r_addr  <= m0_addr;
        r_wdata <= m0_wdata;
        r_prio  <= 1'b1;
      end else if (w_grant1) begin
        r_we    <= m1_we;
        r_addr  <= m1_addr;
        r_wdata <= m1_wdata;
        r_prio  <= 1'b0;
      end
      if (w_complete) begin
        if (r_state == GNT0) begin
          r_m0_done  <= 1'b1;
          r_m0_rdata <= w_cap_data;
        end else begin
          r_m1_done  <= 1'b1;
          r_m1_rdata <= w_cap_data;
        end
      end
    end
  end

  assign m0_done  = r_m0_done;
  assign m1_done  = r_m1_done;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;
  assign bus_busy = (r_state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a transaction-level reference model.
module tb_bus_arbiter;

`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
  logic        m0_done;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
  logic        m1_done;
  logic        bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        bus_busy, bus_err;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, what was latched, how long it has waited.
  int          m_owner;
  int          m_prio;
  int          m_wait;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_done0, m_done1;
  logic [31:0] m_rdata0, m_rdata1;
  logic        m_err;

  bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .bus_busy(bus_busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1; m_prio = 0; m_wait = 0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_done0 = 1'b0; m_done1 = 1'b0;
    m_rdata0 = '0; m_rdata1 = '0; m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
  endtask

  // Advance one clock: the model consumes the inputs the DUT will sample.
  task automatic tick();
    int g;
    logic to;
    logic [31:0] data;
    m_done0 = 1'b0;
    m_done1 = 1'b0;
    if (m_owner < 0) begin
      g = -1;
      if (m0_req && m1_req) g = m_prio;
      else if (m0_req) g = 0;
      else if (m1_req) g = 1;
      if (g == 0) begin m_we = m0_we; m_addr = m0_addr; m_wdata = m0_wdata; end
      if (g == 1) begin m_we = m1_we; m_addr = m1_addr; m_wdata = m1_wdata; end
      if (g >= 0) begin m_owner = g; m_prio = 1 - g; m_wait = 0; end
    end else begin
      to = TO_EN && !bus_ready && (m_wait == 15);
      if (bus_ready || to) begin
        data = to ? 32'hDEAD_BEEF : (m_we ? 32'h0 : bus_rdata);
        if (m_owner == 0) begin m_done0 = 1'b1; m_rdata0 = data; end
        else begin m_done1 = 1'b1; m_rdata1 = data; end
        if (to) m_err = 1'b1;
        m_owner = -1;
      end else begin
        m_wait++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if (bus_busy !== 1'b0 || bus_addr !== 32'hFFFF_FFFF || bus_we !== 1'b0 || bus_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus busy=%b addr=%h we=%b wdata=%h required busy=0 addr=ffffffff we=0 wdata=0",
               bus_busy, bus_addr, bus_we, bus_wdata);
    end
    checks++;
    if (m0_done !== 1'b0 || m1_done !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_masters done=%b%b rdata0=%h rdata1=%h err=%b required all zero",
               m0_done, m1_done, m0_rdata, m1_rdata, bus_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_read_latency();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    checks++;
    if (bus_busy !== 1'b1 || bus_addr !== 32'h0000_0010 || bus_we !== 1'b0) begin
      errors++;
      $display("FAIL read_grant busy=%b addr=%h we=%b required busy=1 addr=00000010 we=0", bus_busy, bus_addr, bus_we);
    end
    m0_req = 1'b0;
    tick();
    checks++;
    if (m0_done !== 1'b1 || m0_rdata !== 32'h1234_5678 || bus_busy !== 1'b0 || bus_addr !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL read_done done=%b rdata=%h busy=%b addr=%h required done=1 rdata=12345678 busy=0 addr=ffffffff",
               m0_done, m0_rdata, bus_busy, bus_addr);
    end
    $display("txn m0 read addr=00000010 rdata=%h", m0_rdata);
    tick();
    checks++;
    if (m0_done !== 1'b0 || m0_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_pulse done=%b rdata=%h required done=0 rdata=12345678", m0_done, m0_rdata);
    end
  endtask

  task automatic test_both_same_cycle();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0020;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0030; m1_wdata = 32'hAAAA_5555;
    bus_ready = 1'b1; bus_rdata = 32'hCAFE_0001;
    tick();
    checks++;
    if (bus_addr !== 32'h0000_0020 || bus_we !== 1'b0) begin
      errors++;
      $display("FAIL both_first addr=%h we=%b required addr=00000020 we=0", bus_addr, bus_we);
    end
    tick();
    checks++;
    if (m0_done !== 1'b1 || m1_done !== 1'b0 || m0_rdata !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL both_m0done done=%b%b rdata0=%h required m0 done only rdata0=cafe0001", m0_done, m1_done, m0_rdata);
    end
    m0_req = 1'b0;
    tick();
    checks++;
    if (bus_we !== 1'b1 || bus_addr !== 32'h0000_0030 || bus_wdata !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL both_second we=%b addr=%h wdata=%h required we=1 addr=00000030 wdata=aaaa5555",
               bus_we, bus_addr, bus_wdata);
    end
    m1_req = 1'b0;
    tick();
    checks++;
    if (m1_done !== 1'b1 || m0_done !== 1'b0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL both_m1done done=%b%b rdata1=%h required m1 done only rdata1=0", m0_done, m1_done, m1_rdata);
    end
    $display("txn m0 read then m1 write, m1 done=%b", m1_done);
  endtask

  task automatic test_alternate();
    int expect_next = 0;
    int ndone = 0;
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; bus_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_rdata = $urandom;
      tick();
      checks++;
      if (m0_done && m1_done) begin
        errors++;
        $display("FAIL alt_overlap cycle=%0d both done high required at most one", i);
      end
      if (m0_done || m1_done) begin
        checks++;
        if (m1_done !== expect_next[0]) begin
          errors++;
          $display("FAIL alt_order cycle=%0d got m%0d required m%0d", i, m1_done ? 1 : 0, expect_next);
        end
        $display("txn alternate grant m%0d", m1_done ? 1 : 0);
        expect_next = 1 - expect_next;
        ndone++;
      end
    end
    checks++;
    if (ndone != 8) begin
      errors++;
      $display("FAIL alt_count dones=%0d required 8", ndone);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_hold_addr();
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hFFFF_F000; m1_wdata = 32'h0000_0005;
    bus_ready = 1'b0;
    tick();
    m1_addr = 32'h0000_1234; m1_wdata = 32'h9999_9999; m1_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus_addr !== 32'hFFFF_F000 || bus_wdata !== 32'h5 || bus_we !== 1'b1 || m1_done !== 1'b0 || bus_busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_wait cycle=%0d addr=%h wdata=%h we=%b done=%b busy=%b required fffff000/5/1/0/1",
                 i, bus_addr, bus_wdata, bus_we, m1_done, bus_busy);
      end
    end
    bus_ready = 1'b1;
    tick();
    checks++;
    if (m1_done !== 1'b1 || bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_done done=%b busy=%b required done=1 busy=0", m1_done, bus_busy);
    end
    $display("txn m1 write addr=fffff000 held through wait");
    m1_req = 1'b0;
    bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0040;
    bus_ready = 1'b0; bus_rdata = 32'h5555_5555;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (m0_done !== 1'b0 || bus_busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_wait cycle=%0d done=%b busy=%b required done=0 busy=1", i, m0_done, bus_busy);
      end
    end
    tick();
    checks++;
    if (TO_EN) begin
      if (m0_done !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || bus_err !== 1'b1 || bus_busy !== 1'b0) begin
        errors++;
        $display("FAIL timeout_fire done=%b rdata=%h err=%b busy=%b required 1/deadbeef/1/0",
                 m0_done, m0_rdata, bus_err, bus_busy);
      end
      m0_req = 1'b0;
      tick();
      tick();
      checks++;
      if (bus_err !== 1'b1) begin
        errors++;
        $display("FAIL timeout_sticky err=%b required 1", bus_err);
      end
    end else begin
      if (m0_done !== 1'b0 || bus_busy !== 1'b1 || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_none done=%b busy=%b err=%b required 0/1/0", m0_done, bus_busy, bus_err);
      end
      bus_ready = 1'b1;
      m0_req = 1'b0;
      tick();
      checks++;
      if (m0_done !== 1'b1 || m0_rdata !== 32'h5555_5555) begin
        errors++;
        $display("FAIL timeout_late_ready done=%b rdata=%h required 1/55555555", m0_done, m0_rdata);
      end
    end
    $display("txn m0 long wait rdata=%h err=%b", m0_rdata, bus_err);
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0050;
    bus_ready = 1'b0;
    tick();
    checks++;
    if (bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant busy=%b required 1", bus_busy);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus_busy !== 1'b0 || bus_addr !== 32'hFFFF_FFFF || m0_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async busy=%b addr=%h done=%b required 0/ffffffff/0", bus_busy, bus_addr, m0_done);
    end
    m0_req = 1'b0;
    bus_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (m0_done !== 1'b0 || bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after done=%b busy=%b required 0/0", m0_done, bus_busy);
    end
    // After reset prio is 0 again, so a simultaneous request goes to m0.
    m0_req = 1'b1; m0_addr = 32'h0000_0060;
    m1_req = 1'b1; m1_addr = 32'h0000_0070;
    tick();
    checks++;
    if (bus_addr !== 32'h0000_0060) begin
      errors++;
      $display("FAIL rstmid_prio addr=%h required 00000060", bus_addr);
    end
    $display("txn reset abandoned m0, next grant addr=%h", bus_addr);
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      m0_req    = ($urandom_range(0, 9) < 7);
      m0_we     = $urandom_range(0, 1);
      m0_addr   = $urandom;
      m0_wdata  = $urandom;
      m1_req    = ($urandom_range(0, 9) < 7);
      m1_we     = $urandom_range(0, 1);
      m1_addr   = $urandom;
      m1_wdata  = $urandom;
      bus_ready = ($urandom_range(0, 9) < 6);
      bus_rdata = $urandom;
      tick();
      checks++;
      if (bus_busy !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL rnd_busy cycle=%0d got %b required %b", i, bus_busy, (m_owner >= 0));
      end
      checks++;
      if (bus_addr !== ((m_owner >= 0) ? m_addr : 32'hFFFF_FFFF) ||
          bus_we !== ((m_owner >= 0) ? m_we : 1'b0) ||
          bus_wdata !== ((m_owner >= 0) ? m_wdata : 32'h0)) begin
        errors++;
        $display("FAIL rnd_bus cycle=%0d addr=%h we=%b wdata=%h required owner=%0d addr=%h we=%b wdata=%h",
                 i, bus_addr, bus_we, bus_wdata, m_owner, m_addr, m_we, m_wdata);
      end
      checks++;
      if (m0_done !== m_done0 || m1_done !== m_done1) begin
        errors++;
        $display("FAIL rnd_done cycle=%0d got %b%b required %b%b", i, m0_done, m1_done, m_done0, m_done1);
      end
      checks++;
      if (m0_rdata !== m_rdata0 || m1_rdata !== m_rdata1) begin
        errors++;
        $display("FAIL rnd_rdata cycle=%0d got %h/%h required %h/%h", i, m0_rdata, m1_rdata, m_rdata0, m_rdata1);
      end
      checks++;
      if (bus_err !== m_err) begin
        errors++;
        $display("FAIL rnd_err cycle=%0d got %b required %b", i, bus_err, m_err);
      end
      if (m_done0) $display("txn rnd m0 done rdata=%h", m0_rdata);
      if (m_done1) $display("txn rnd m1 done rdata=%h", m1_rdata);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_read_latency();
    test_both_same_cycle();
    test_alternate();
    test_hold_addr();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
